// File: rtl/gtech_clk_gate_pkg.sv
// Shared definitions for the gated-clock unit of the DSP sequencer.
// Holds the GATE_MODE encodings and the default number of gated domains.
package gtech_clk_gate_pkg;

    // Structural gating: GCLK = DSPCLK OR dis (held high while disabled).
    localparam int GM_STRUCT       = 1;
    // Free-running clock; consumers qualify updates with GCLK_en.
    localparam int GM_QUAL         = 0;
    // Default number of independent gated-clock domains.
    localparam int DEFAULT_NUM_DOM = 1;

endpackage : gtech_clk_gate_pkg

// File: rtl/gtech_clk_gate_cell.sv
// Single-domain clock-gating cell: AND-NOT disable qualifier, NOR2 and
// clock inverter. The clock path from i_clk to o_gclk is purely
// combinational through two cell levels (NOR2 then inverter).
//
// Ports:
//   i_clk      master clock (DSPCLK)
//   i_dis_req  disable request for this domain, active-high
//   i_scan     scan-test override, forces the domain enabled
//   o_gclk     gated clock (structural mode) or DSPCLK (qualifier mode)
//   o_gclk_en  enable qualifier, active-high
module gtech_clk_gate_cell
    import gtech_clk_gate_pkg::*;
#(
    parameter int GATE_MODE = GM_STRUCT
) (
    input  logic i_clk,
    input  logic i_dis_req,
    input  logic i_scan,
    output logic o_gclk,
    output logic o_gclk_en
);

    logic w_dis;

    // AND-NOT: scan mode overrides any disable request.
    assign w_dis     = i_dis_req & ~i_scan;
    assign o_gclk_en = ~w_dis;

    generate
        if (GATE_MODE == GM_QUAL) begin : g_qual
            // Clock runs free; gating is done by consumers via o_gclk_en.
            assign o_gclk = i_clk;
        end else begin : g_struct
            logic w_gclk_n;
            // NOR2 then clock inverter: GCLK = clk | dis. While disabled the
            // output sits high, so no rising edges reach the consumers.
            assign w_gclk_n = ~(i_clk | w_dis);
            assign o_gclk   = ~w_gclk_n;
        end
    endgenerate

endmodule : gtech_clk_gate_cell

// File: rtl/gtech_clk_gate.sv
// Clock-gating unit for the DSP sequencer's gated-clock domains (e.g. the
// status-stack clock STSCLK). One gating cell per domain, optionally fed by
// a disable register launched on the DSPCLK rising edge.
//
// Parameters:
//   NUM_DOM    number of gated-clock domains
//   GATE_MODE  GM_STRUCT = structural gating, GM_QUAL = enable qualifier
//   REG_DIS    1 = register CKenb on DSPCLK rising edge before use
//
// Ports:
//   DSPCLK     master DSP clock
//   T_RST      asynchronous active-low reset (disable register only)
//   SCAN_TEST  scan mode, forces every domain enabled
//   CKenb      per-domain clock-disable request, active-high
//   GCLK       per-domain gated clock
//   GCLK_en    per-domain enable qualifier, active-high
module gtech_clk_gate
    import gtech_clk_gate_pkg::*;
#(
    parameter int NUM_DOM   = DEFAULT_NUM_DOM,
    parameter int GATE_MODE = GM_STRUCT,
    parameter int REG_DIS   = 0
) (
    input  logic               DSPCLK,
    input  logic               T_RST,
    input  logic               SCAN_TEST,
    input  logic [NUM_DOM-1:0] CKenb,
    output logic [NUM_DOM-1:0] GCLK,
    output logic [NUM_DOM-1:0] GCLK_en
);

    logic [NUM_DOM-1:0] w_dis_src;

    generate
        if (REG_DIS != 0) begin : g_reg
            logic [NUM_DOM-1:0] r_dis_req;

            // Disable register: changes only just after the rising edge, so
            // dis moves while DSPCLK is high and GCLK cannot glitch. Reset
            // clears it so every domain clocks during reset.
            always_ff @(posedge DSPCLK or negedge T_RST) begin
                if (!T_RST) begin
                    r_dis_req <= '0;
                end else begin
                    r_dis_req <= CKenb;
                end
            end

            assign w_dis_src = r_dis_req;
        end else begin : g_direct
            // Reset has no role without the disable register.
            logic w_unused_rst;
            assign w_unused_rst = T_RST;
            assign w_dis_src    = CKenb;
        end
    endgenerate

    for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_dom
        (* dont_touch = "true" *)
        gtech_clk_gate_cell #(
            .GATE_MODE (GATE_MODE)
        ) u_cell (
            .i_clk     (DSPCLK),
            .i_dis_req (w_dis_src[gi]),
            .i_scan    (SCAN_TEST),
            .o_gclk    (GCLK[gi]),
            .o_gclk_en (GCLK_en[gi])
        );
    end

endmodule : gtech_clk_gate

// File: tb/tb_gtech_clk_gate.sv
// Self-checking bench for gtech_clk_gate. Three instances share stimulus:
// structural/direct, structural/registered, qualifier/direct, NUM_DOM=3.
module tb_gtech_clk_gate;

    logic       DSPCLK;
    logic       T_RST;
    logic       SCAN_TEST;
    logic [2:0] CKenb;
    logic [2:0] g_a, e_a, g_r, e_r, g_q, e_q;

    gtech_clk_gate #(.NUM_DOM(3), .GATE_MODE(1), .REG_DIS(0)) u_dut_a (
        .DSPCLK(DSPCLK), .T_RST(T_RST), .SCAN_TEST(SCAN_TEST),
        .CKenb(CKenb), .GCLK(g_a), .GCLK_en(e_a));
    gtech_clk_gate #(.NUM_DOM(3), .GATE_MODE(1), .REG_DIS(1)) u_dut_r (
        .DSPCLK(DSPCLK), .T_RST(T_RST), .SCAN_TEST(SCAN_TEST),
        .CKenb(CKenb), .GCLK(g_r), .GCLK_en(e_r));
    gtech_clk_gate #(.NUM_DOM(3), .GATE_MODE(0), .REG_DIS(0)) u_dut_q (
        .DSPCLK(DSPCLK), .T_RST(T_RST), .SCAN_TEST(SCAN_TEST),
        .CKenb(CKenb), .GCLK(g_q), .GCLK_en(e_q));

    int checks = 0;
    int errors = 0;

    // Rows: 0 = direct, 1 = registered, 2 = qualifier, 3 = qualified consumer
    int cnt  [4][3];
    int base [4][3];
    int exp_e[4][3];

    logic [2:0] prev_a, prev_r, prev_q;
    logic [2:0] m_last_ck;
    logic [2:0] m_reg;
    logic [17:0] obs_hi, obs_lo, exp_hi, exp_lo;
    int cyc = 0;

    initial DSPCLK = 1'b0;
    always #5 DSPCLK = ~DSPCLK;

    // Rising-edge counters (any runt pulse also shows up as an extra edge).
    always @(g_a) begin
        for (int i = 0; i < 3; i++)
            if (g_a[i] === 1'b1 && prev_a[i] === 1'b0) cnt[0][i]++;
        prev_a = g_a;
    end
    always @(g_r) begin
        for (int i = 0; i < 3; i++)
            if (g_r[i] === 1'b1 && prev_r[i] === 1'b0) cnt[1][i]++;
        prev_r = g_r;
    end
    always @(g_q) begin
        for (int i = 0; i < 3; i++) begin
            if (g_q[i] === 1'b1 && prev_q[i] === 1'b0) begin
                cnt[2][i]++;
                if (e_q[i] === 1'b1) cnt[3][i]++;
            end
        end
        prev_q = g_q;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic mark();
        for (int d = 0; d < 4; d++)
            for (int i = 0; i < 3; i++) begin
                base[d][i]  = cnt[d][i];
                exp_e[d][i] = 0;
            end
    endtask

    // One DSPCLK cycle, entered and left at posedge+1. Inputs change while
    // DSPCLK is high; outputs are snapshotted mid-high and mid-low. The model
    // works from the behavioural rules: disable = request AND NOT scan,
    // registered request = CKenb seen at the last edge (0 under reset).
    task automatic run_cycle(input logic [2:0] ck, input logic sc, input logic rst);
        logic [2:0] dis_a, dis_r;
        if (T_RST === 1'b0) m_reg = 3'b000;
        else                m_reg = m_last_ck;
        CKenb     = ck;
        SCAN_TEST = sc;
        T_RST     = rst;
        if (!rst) m_reg = 3'b000;
        m_last_ck = ck;
        dis_a = ck & ~{3{sc}};
        dis_r = m_reg & ~{3{sc}};
        #2;
        obs_hi = {g_a, e_a, g_r, e_r, g_q, e_q};
        exp_hi = {3'b111, ~dis_a, 3'b111, ~dis_r, 3'b111, ~dis_a};
        @(negedge DSPCLK);
        #3;
        obs_lo = {g_a, e_a, g_r, e_r, g_q, e_q};
        exp_lo = {dis_a, ~dis_a, dis_r, ~dis_r, 3'b000, ~dis_a};
        for (int i = 0; i < 3; i++) begin
            exp_e[0][i] += (dis_a[i] ? 0 : 1);
            exp_e[1][i] += (dis_r[i] ? 0 : 1);
            exp_e[2][i] += 1;
            exp_e[3][i] += (dis_a[i] ? 0 : 1);
        end
        cyc++;
        @(posedge DSPCLK);
        #1;
    endtask

    task automatic test_reset();
        mark();
        for (int k = 0; k < 8; k++) begin
            // three cycles in reset, release at k=3, then gating takes over
            run_cycle(3'b111, 1'b0, (k >= 3));
            checks++;
            if (obs_hi !== exp_hi) begin
                errors++;
                $display("FAIL reset_hi cyc=%0d got=%h exp=%h", cyc, obs_hi, exp_hi);
            end
            checks++;
            if (obs_lo !== exp_lo) begin
                errors++;
                $display("FAIL reset_lo cyc=%0d got=%h exp=%h", cyc, obs_lo, exp_lo);
            end
        end
        for (int d = 0; d < 4; d++)
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (cnt[d][i] - base[d][i] !== exp_e[d][i]) begin
                    errors++;
                    $display("FAIL reset_edges row=%0d dom=%0d got=%0d exp=%0d",
                             d, i, cnt[d][i] - base[d][i], exp_e[d][i]);
                end
            end
        // registered domain: edges in reset (3) + first edge after release (1)
        checks++;
        if (cnt[1][0] - base[1][0] !== 4) begin
            errors++;
            $display("FAIL reset_reg_gate_start got=%0d exp=4", cnt[1][0] - base[1][0]);
        end
    endtask

    task automatic test_gating();
        logic [2:0] pat [0:21];
        for (int k = 0; k < 22; k++) begin
            if (k < 10)      pat[k] = 3'b000;   // pass-through
            else if (k < 15) pat[k] = 3'b111;   // gated
            else if (k < 17) pat[k] = 3'b000;   // re-enabled
            else             pat[k] = 3'b101;   // only domain 1 runs
        end
        mark();
        for (int k = 0; k < 22; k++) begin
            run_cycle(pat[k], 1'b0, 1'b1);
            checks++;
            if (obs_hi !== exp_hi) begin
                errors++;
                $display("FAIL gating_hi cyc=%0d got=%h exp=%h", cyc, obs_hi, exp_hi);
            end
            checks++;
            if (obs_lo !== exp_lo) begin
                errors++;
                $display("FAIL gating_lo cyc=%0d got=%h exp=%h", cyc, obs_lo, exp_lo);
            end
        end
        for (int d = 0; d < 4; d++)
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (cnt[d][i] - base[d][i] !== exp_e[d][i]) begin
                    errors++;
                    $display("FAIL gating_edges row=%0d dom=%0d got=%0d exp=%0d",
                             d, i, cnt[d][i] - base[d][i], exp_e[d][i]);
                end
            end
    endtask

    task automatic test_scan();
        mark();
        for (int k = 0; k < 8; k++) begin
            run_cycle(3'b111, (k < 4), 1'b1);
            checks++;
            if (obs_hi !== exp_hi) begin
                errors++;
                $display("FAIL scan_hi cyc=%0d got=%h exp=%h", cyc, obs_hi, exp_hi);
            end
            checks++;
            if (obs_lo !== exp_lo) begin
                errors++;
                $display("FAIL scan_lo cyc=%0d got=%h exp=%h", cyc, obs_lo, exp_lo);
            end
        end
        for (int d = 0; d < 4; d++)
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (cnt[d][i] - base[d][i] !== exp_e[d][i]) begin
                    errors++;
                    $display("FAIL scan_edges row=%0d dom=%0d got=%0d exp=%0d",
                             d, i, cnt[d][i] - base[d][i], exp_e[d][i]);
                end
            end
    endtask

    task automatic test_random();
        logic [2:0] ck;
        logic       sc;
        mark();
        for (int k = 0; k < 60; k++) begin
            ck = 3'($urandom_range(0, 7));
            sc = ($urandom_range(0, 5) == 0);
            run_cycle(ck, sc, 1'b1);
            checks++;
            if (obs_hi !== exp_hi) begin
                errors++;
                $display("FAIL random_hi cyc=%0d got=%h exp=%h", cyc, obs_hi, exp_hi);
            end
            checks++;
            if (obs_lo !== exp_lo) begin
                errors++;
                $display("FAIL random_lo cyc=%0d got=%h exp=%h", cyc, obs_lo, exp_lo);
            end
        end
        for (int d = 0; d < 4; d++)
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (cnt[d][i] - base[d][i] !== exp_e[d][i]) begin
                    errors++;
                    $display("FAIL random_edges row=%0d dom=%0d got=%0d exp=%0d",
                             d, i, cnt[d][i] - base[d][i], exp_e[d][i]);
                end
            end
    endtask

    initial begin
        T_RST     = 1'b0;
        SCAN_TEST = 1'b0;
        CKenb     = 3'b000;
        m_last_ck = 3'b000;
        m_reg     = 3'b000;
        @(posedge DSPCLK);
        #1;
        test_reset();
        test_gating();
        test_scan();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gtech_clk_gate
